// File: rtl/pattern_scan_ctrl.sv
// -----------------------------------------------------------------------------
// pattern_scan_ctrl
//
// Two-requester serial pattern scanner. When IDLE, the block grants one
// requester round-robin and latches its 16-bit word. It then shifts the word
// MSB first through a serial detector for the pattern 1-0-0-1-0, one bit per
// cycle. Overlapping matches are counted, and the count saturates at 15.
// When the scan ends, a one-cycle result pulse is issued.
//
// Timing: accept at cycle T, res_valid at T+17, next accept no earlier than
// T+18.
//
// Optional feature (macro PSCAN_LAST_POS_EN): adds the output last_pos. This
// is the bit index (0 = MSB) that completed the last match in the word. It is
// 0 when there was no match.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   req0_valid  requester 0 has a word to scan
//   req0_data   requester 0 word (16 bits)
//   req0_ready  requester 0 word accepted this cycle
//   req1_*      same as requester 0
//   res_valid   one-cycle result pulse
//   res_id      requester index of the result (held until next result)
//   res_count   number of pattern matches (held until next result)
//   busy        high while scanning or presenting a result
//   last_pos    (PSCAN_LAST_POS_EN only) index that completed the last match
// -----------------------------------------------------------------------------
module pattern_scan_ctrl #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              res_valid,
   output logic              res_id,
   output logic [3:0]        res_count,
   output logic              busy
`ifdef PSCAN_LAST_POS_EN
   ,
   output logic [3:0]        last_pos
`endif
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_RESULT = 2'd2
   } state_t;

   // Detector state names the longest prefix of 1-0-0-1-0 seen so far.
   typedef enum logic [2:0] {
      D0 = 3'd0,
      D1 = 3'd1,
      D2 = 3'd2,
      D3 = 3'd3,
      D4 = 3'd4
   } det_t;

   localparam logic [3:0] LAST_IDX = 4'd15;

   // Saturating increment of the 4-bit match counter.
   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      sat_inc = (v == 4'hF) ? v : v + 4'd1;
   endfunction

   // Next detector state for one serial bit.
   function automatic det_t det_next(input det_t s, input logic b);
      unique case (s)
         D0:      det_next = b ? D1 : D0;
         D1:      det_next = b ? D1 : D2;
         D2:      det_next = b ? D1 : D3;
         D3:      det_next = b ? D4 : D0;
         D4:      det_next = b ? D1 : D2;
         default: det_next = D0;
      endcase
   endfunction

   // Only a 0 arriving in D4 completes a match. After the match, the
   // trailing "1-0" is reused as the prefix for an overlapping match (D2).
   function automatic logic det_hit(input det_t s, input logic b);
      det_hit = (s == D4) && !b;
   endfunction

   state_t            state_q, state_d;
   det_t              det_q;
   logic [DATA_W-1:0] word_q;
   logic [3:0]        idx_q;
   logic [3:0]        cnt_q;
   logic              last_grant_q;
   logic              cur_id_q;
   logic              res_id_q;
   logic [3:0]        res_count_q;

   logic              grant0, grant1;
   logic              cur_bit;
   logic              hit;
   logic [3:0]        cnt_nxt;
   logic              scan_done;

   // Round-robin grant. It is only possible in IDLE, and is suppressed
   // during reset so that ready stays low.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state_q == S_IDLE && !rst) begin
         if (req0_valid && req1_valid) begin
            if (last_grant_q) grant0 = 1'b1;
            else              grant1 = 1'b1;
         end else if (req0_valid) begin
            grant0 = 1'b1;
         end else if (req1_valid) begin
            grant1 = 1'b1;
         end
      end
   end

   // The latched word is shifted left every SHIFT cycle, so the bit under
   // scan is always the MSB.
   assign cur_bit   = word_q[DATA_W-1];
   assign hit       = (state_q == S_SHIFT) && det_hit(det_q, cur_bit);
   assign cnt_nxt   = hit ? sat_inc(cnt_q) : cnt_q;
   assign scan_done = (state_q == S_SHIFT) && (idx_q == LAST_IDX);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (grant0 || grant1) state_d = S_SHIFT;
         S_SHIFT:  if (idx_q == LAST_IDX) state_d = S_RESULT;
         S_RESULT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         det_q        <= D0;
         idx_q        <= 4'd0;
         cnt_q        <= 4'd0;
         last_grant_q <= 1'b1;
         cur_id_q     <= 1'b0;
         res_id_q     <= 1'b0;
         res_count_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         // Accept: start each word from a clean detector and counter.
         if (grant0 || grant1) begin
            det_q        <= D0;
            idx_q        <= 4'd0;
            cnt_q        <= 4'd0;
            cur_id_q     <= grant1;
            last_grant_q <= grant1;
         end else if (state_q == S_SHIFT) begin
            det_q <= det_next(det_q, cur_bit);
            idx_q <= idx_q + 4'd1;
            cnt_q <= cnt_nxt;
         end
         // Publish the result, including a match on the final bit.
         if (scan_done) begin
            res_id_q    <= cur_id_q;
            res_count_q <= cnt_nxt;
         end
      end
   end

   // Word register carries data only and needs no reset.
   always_ff @(posedge clk) begin
      if (grant0)
         word_q <= req0_data;
      else if (grant1)
         word_q <= req1_data;
      else if (state_q == S_SHIFT)
         word_q <= {word_q[DATA_W-2:0], 1'b0};
   end

`ifdef PSCAN_LAST_POS_EN
   logic [3:0] lp_scan_q;
   logic [3:0] last_pos_q;

   // lp_scan_q tracks the most recent completing index within the word.
   // It starts at 0, so a word with no match reports 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         lp_scan_q  <= 4'd0;
         last_pos_q <= 4'd0;
      end else begin
         if (grant0 || grant1)
            lp_scan_q <= 4'd0;
         else if (hit)
            lp_scan_q <= idx_q;
         if (scan_done)
            last_pos_q <= hit ? idx_q : lp_scan_q;
      end
   end

   assign last_pos = last_pos_q;
`endif

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign res_valid  = (state_q == S_RESULT);
   assign res_id     = res_id_q;
   assign res_count  = res_count_q;
   assign busy       = (state_q != S_IDLE);

endmodule
